io_timer: RTL

IO_TIMER -- requirements
Module: io_timer

---
 rtl/io_timer.sv | 105 ++++++++++
 1 files changed

// File: rtl/io_timer.sv
// Byte-wide memory-mapped 16-bit timer with prescaler, compare match, auto-reload
// and a coherent LO->HI counter read path through an 8-bit shadow register.
module io_timer #(
  parameter int PW = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] io_addr,
  input  logic       io_write,
  input  logic       io_read,
  input  logic [7:0] io_wdata,
  output logic [7:0] io_rdata,
  output logic       irq
);

  localparam logic [3:0] A_CNT_LO = 4'd0;
  localparam logic [3:0] A_CNT_HI = 4'd1;
  localparam logic [3:0] A_CMP_LO = 4'd2;
  localparam logic [3:0] A_CMP_HI = 4'd3;
  localparam logic [3:0] A_CTRL   = 4'd4;
  localparam logic [3:0] A_STATUS = 4'd5;

  logic [15:0]   cnt;
  logic [15:0]   cmp;
  logic [7:0]    staging;
  logic [7:0]    shadow;
  logic [PW-1:0] prescaler;
  logic [PW-1:0] ps_mask;
  logic          en, ie, ar, pend;
  logic [2:0]    ps;
  logic          tick, match;
  logic          wr_cnt_lo, wr_cnt_hi, wr_cmp_lo, wr_cmp_hi, wr_ctrl, wr_status;

  assign wr_cnt_lo = io_write && (io_addr == A_CNT_LO);
  assign wr_cnt_hi = io_write && (io_addr == A_CNT_HI);
  assign wr_cmp_lo = io_write && (io_addr == A_CMP_LO);
  assign wr_cmp_hi = io_write && (io_addr == A_CMP_HI);
  assign wr_ctrl   = io_write && (io_addr == A_CTRL);
  assign wr_status = io_write && (io_addr == A_STATUS);

  // PS values above PW naturally saturate to an all-ones mask of width PW.
  always_comb begin
    ps_mask = '0;
    for (int i = 0; i < PW; i++) ps_mask[i] = (i < int'(ps));
  end

  assign tick  = en && ((prescaler & ps_mask) == ps_mask);
  assign match = (cnt == cmp);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= 16'h0000;
      cmp       <= 16'hFFFF;
      staging   <= 8'h00;
      shadow    <= 8'h00;
      prescaler <= '0;
      en        <= 1'b0;
      ie        <= 1'b0;
      ar        <= 1'b0;
      ps        <= 3'd0;
      pend      <= 1'b0;
    end else begin
      if (wr_cnt_lo) staging <= io_wdata;
      if (io_read && (io_addr == A_CNT_LO)) shadow <= cnt[15:8];

      // A CNT_HI write takes priority over any tick in the same cycle.
      if (wr_cnt_hi)  cnt <= {io_wdata, staging};
      else if (tick)  cnt <= (match && ar) ? 16'h0000 : cnt + 16'd1;

      if (wr_cnt_hi)  prescaler <= '0;
      else if (en)    prescaler <= prescaler + 1'b1;
      else            prescaler <= '0;

      if (wr_cmp_lo) cmp[7:0]  <= io_wdata;
      if (wr_cmp_hi) cmp[15:8] <= io_wdata;

      if (wr_ctrl) begin
        en <= io_wdata[0];
        ie <= io_wdata[1];
        ar <= io_wdata[2];
        ps <= io_wdata[5:3];
      end

      // A match tick beats a simultaneous software clear.
      if (tick && match)                pend <= 1'b1;
      else if (wr_status && io_wdata[0]) pend <= 1'b0;
    end
  end

  always_comb begin
    io_rdata = 8'h00;
    case (io_addr)
      A_CNT_LO: io_rdata = cnt[7:0];
      A_CNT_HI: io_rdata = shadow;
      A_CMP_LO: io_rdata = cmp[7:0];
      A_CMP_HI: io_rdata = cmp[15:8];
      A_CTRL:   io_rdata = {2'b00, ps, ar, ie, en};
      A_STATUS: io_rdata = {7'b0, pend};
      default:  io_rdata = 8'h00;
    endcase
  end

  assign irq = pend & ie;

endmodule
